// File: rtl/writeback_arbiter_if.sv
// Producer-side request bus and ROB-side writeback bus of the writeback arbiter.
// master: execution units / ROB side; slave: the arbiter.
interface writeback_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*5-1:0]  req_vregid;
    logic [NUM_REQ*32-1:0] req_val;
    logic [NUM_REQ-1:0]    req_ready;

    logic        writeback1_en;
    logic [4:0]  writeback1_vregid;
    logic [31:0] writeback1_val;
    logic        writeback2_en;
    logic [4:0]  writeback2_vregid;
    logic [31:0] writeback2_val;
    logic        writeback3_en;
    logic [4:0]  writeback3_vregid;
    logic [31:0] writeback3_val;
    logic        busy;

    modport master (
        output req_valid, req_vregid, req_val,
        input  req_ready,
        input  writeback1_en, writeback1_vregid, writeback1_val,
        input  writeback2_en, writeback2_vregid, writeback2_val,
        input  writeback3_en, writeback3_vregid, writeback3_val,
        input  busy
    );

    modport slave (
        input  req_valid, req_vregid, req_val,
        output req_ready,
        output writeback1_en, writeback1_vregid, writeback1_val,
        output writeback2_en, writeback2_vregid, writeback2_val,
        output writeback3_en, writeback3_vregid, writeback3_val,
        output busy
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Per-producer result FIFOs with a round-robin arbiter onto three registered ROB writeback ports.
// Optional macro WB_ARB_STATS_EN adds the saturating stall_cycles contention counter.
module writeback_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
`ifdef WB_ARB_STATS_EN
    output logic [31:0] stall_cycles,
`endif
    writeback_arbiter_if.slave bus
);
    localparam int unsigned ID_W      = 5;
    localparam int unsigned VAL_W     = 32;
    localparam int unsigned NUM_SLOTS = 3;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned IDX_W     = $clog2(NUM_REQ);

    logic [ID_W-1:0]  r_mem_id  [NUM_REQ][DEPTH];
    logic [VAL_W-1:0] r_mem_val [NUM_REQ][DEPTH];
    logic [PTR_W-1:0] r_wr_ptr  [NUM_REQ];
    logic [PTR_W-1:0] r_rd_ptr  [NUM_REQ];
    logic [CNT_W-1:0] r_count   [NUM_REQ];
    logic [NUM_REQ-1:0] r_ready;
    logic               r_busy;
    logic [IDX_W-1:0]   r_rr_ptr;

    logic [NUM_SLOTS-1:0] r_wb_en;
    logic [ID_W-1:0]      r_wb_id  [NUM_SLOTS];
    logic [VAL_W-1:0]     r_wb_val [NUM_SLOTS];

    logic [NUM_REQ-1:0]   w_nonempty;
    logic [NUM_REQ-1:0]   w_push;
    logic [NUM_REQ-1:0]   w_pop;
    logic [CNT_W-1:0]     w_count_next [NUM_REQ];
    logic [NUM_REQ-1:0]   w_ready_next;
    logic                 w_busy_next;
    logic [3:0]           w_ne_cnt;
    logic [IDX_W-1:0]     w_src [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_slot_vld;
    logic [IDX_W-1:0]     w_rr_next;
    logic [IDX_W-1:0]     w_idx;
    logic [1:0]           w_nslot;

    // Round-robin scan from r_rr_ptr; the first three non-empty FIFOs take slots 1..3.
    always_comb begin
        w_pop      = '0;
        w_slot_vld = '0;
        w_rr_next  = r_rr_ptr;
        w_idx      = '0;
        w_nslot    = '0;
        for (int s = 0; s < int'(NUM_SLOTS); s++) begin
            w_src[s] = '0;
        end
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            w_idx = IDX_W'((int'(r_rr_ptr) + k) % int'(NUM_REQ));
            if (w_nonempty[w_idx] && (w_nslot != 2'd3)) begin
                w_pop[w_idx]        = 1'b1;
                w_src[w_nslot]      = w_idx;
                w_slot_vld[w_nslot] = 1'b1;
                w_rr_next           = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
                w_nslot             = w_nslot + 2'd1;
            end
        end
    end

    // Occupancy bookkeeping; ready/busy are precomputed so they leave as flops.
    always_comb begin
        w_busy_next = 1'b0;
        w_ne_cnt    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_nonempty[i]   = (r_count[i] != '0);
            w_push[i]       = bus.req_valid[i] && r_ready[i];
            w_count_next[i] = r_count[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
            w_ready_next[i] = (w_count_next[i] != CNT_W'(DEPTH));
            w_busy_next     = w_busy_next | (w_count_next[i] != '0);
            w_ne_cnt        = w_ne_cnt + 4'(w_nonempty[i]);
        end
    end

    // FIFO storage needs no reset: pointers and counts gate every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_push[i]) begin
                r_mem_id[i][r_wr_ptr[i]]  <= bus.req_vregid[ID_W*i +: ID_W];
                r_mem_val[i][r_wr_ptr[i]] <= bus.req_val[VAL_W*i +: VAL_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                r_count[i]  <= '0;
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
            end
            for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                r_wb_id[s]  <= '0;
                r_wb_val[s] <= '0;
            end
            r_wb_en  <= '0;
            r_rr_ptr <= '0;
            r_ready  <= '1;
            r_busy   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                r_count[i] <= w_count_next[i];
                if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
            end
            // Idle slots drop en but keep their last id/value.
            for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                r_wb_en[s] <= w_slot_vld[s];
                if (w_slot_vld[s]) begin
                    r_wb_id[s]  <= r_mem_id[w_src[s]][r_rd_ptr[w_src[s]]];
                    r_wb_val[s] <= r_mem_val[w_src[s]][r_rd_ptr[w_src[s]]];
                end
            end
            r_rr_ptr <= w_rr_next;
            r_ready  <= w_ready_next;
            r_busy   <= w_busy_next;
        end
    end

`ifdef WB_ARB_STATS_EN
    logic [31:0] r_stall_cycles;

    // Counts cycles where more producers wait than there are writeback slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (!flush && (w_ne_cnt > 4'(NUM_SLOTS)) && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    assign bus.req_ready         = r_ready;
    assign bus.busy              = r_busy;
    assign bus.writeback1_en     = r_wb_en[0];
    assign bus.writeback1_vregid = r_wb_id[0];
    assign bus.writeback1_val    = r_wb_val[0];
    assign bus.writeback2_en     = r_wb_en[1];
    assign bus.writeback2_vregid = r_wb_id[1];
    assign bus.writeback2_val    = r_wb_val[1];
    assign bus.writeback3_en     = r_wb_en[2];
    assign bus.writeback3_vregid = r_wb_id[2];
    assign bus.writeback3_val    = r_wb_val[2];
endmodule
